tohost_monitor: RTL and testbench



---
 rtl/tohost_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_tohost_monitor.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tohost_monitor.sv
// tohost_monitor: round-robin tohost arbiter with exit/console
// decode, console FIFO, pass/fail status and watchdog.
module tohost_monitor #(
  parameter int NUM_HARTS = 2,
  parameter int XLEN      = 32,
  parameter int CON_DEPTH = 8,
  parameter int TIMEOUT   = 100000,
  parameter int CYC_W     = 32,
  parameter int HW        = (NUM_HARTS > 1) ?
                            $clog2(NUM_HARTS) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_HARTS-1:0]      tohost_we,
  input  logic [NUM_HARTS*XLEN-1:0] tohost,
  output logic [NUM_HARTS-1:0]      tohost_ready,
  output logic                      con_valid,
  output logic [7:0]                con_data,
  input  logic                      con_ready,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [HW-1:0]             fail_hart,
  output logic [XLEN-2:0]           exit_code,
  output logic [CYC_W-1:0]          cycles
);

  localparam int AW = (CON_DEPTH > 1) ?
                      $clog2(CON_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C =
    CW'(CON_DEPTH);
  localparam logic [CYC_W-1:0] TO_LIM =
    CYC_W'(TIMEOUT - 1);
  localparam logic [HW-1:0] LAST_H =
    HW'(NUM_HARTS - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_HARTS-1:0] r_exited;
  logic [NUM_HARTS-1:0] w_exited_nxt;
  logic [NUM_HARTS-1:0] w_elig;
  logic                 r_failed;
  logic [HW-1:0]        r_rr;
  logic [HW-1:0]        r_fail_hart;
  logic [XLEN-2:0]      r_exit_code;

  logic [7:0]           r_mem [CON_DEPTH];
  logic [AW-1:0]        r_wp;
  logic [AW-1:0]        r_rp;
  logic [CW-1:0]        r_cnt;
  logic [CYC_W-1:0]     r_cycles;

  logic                 w_gnt_vld;
  logic [HW-1:0]        w_gnt;
  logic [XLEN-1:0]      w_word;
  logic                 w_accept_ok;
  logic                 w_xfer;
  logic                 w_is_exit;
  logic                 w_is_con;
  logic [XLEN-2:0]      w_code;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_to_hit;

  assign w_elig = tohost_we & ~r_exited;

  // Round-robin grant: first eligible hart at or after r_rr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_word    = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (!w_gnt_vld && w_elig[i] &&
          i >= int'(r_rr)) begin
        w_gnt_vld = 1'b1;
        w_gnt     = HW'(i);
        w_word    = tohost[i*XLEN +: XLEN];
      end
    end
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (!w_gnt_vld && w_elig[i] &&
          i < int'(r_rr)) begin
        w_gnt_vld = 1'b1;
        w_gnt     = HW'(i);
        w_word    = tohost[i*XLEN +: XLEN];
      end
    end
  end

  assign w_accept_ok = (r_state == S_RUN) &&
                       (r_cnt < DEPTH_C) && !RST;
  assign w_xfer      = w_accept_ok && w_gnt_vld;
  assign w_is_exit   = w_word[0];
  assign w_is_con    = !w_word[0] && w_word[1];
  assign w_code      = w_word[XLEN-1:1];
  assign w_push      = w_xfer && w_is_con;
  assign w_pop       = con_valid && con_ready;

  // One-hot ready and next exited flags for the granted hart.
  always_comb begin
    tohost_ready = '0;
    w_exited_nxt = r_exited;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (w_xfer && w_gnt == HW'(i)) begin
        tohost_ready[i] = 1'b1;
        if (w_is_exit)
          w_exited_nxt[i] = 1'b1;
      end
    end
  end

  // Next state; the watchdog wins over every other move.
  always_comb begin
    w_state_nxt = r_state;
    w_to_hit    = (TIMEOUT != 0) &&
                  (r_cycles == TO_LIM);
    unique case (r_state)
      S_RUN: begin
        if (w_to_hit)
          w_state_nxt = S_TIMEOUT;
        else if (&w_exited_nxt)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_to_hit)
          w_state_nxt = S_TIMEOUT;
        else if (r_cnt == '0)
          w_state_nxt = S_DONE;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST)
      r_state <= S_RUN;
    else
      r_state <= w_state_nxt;
  end

  // Exit flags, rr pointer and first-failure latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_exited    <= '0;
      r_rr        <= '0;
      r_failed    <= 1'b0;
      r_fail_hart <= '0;
      r_exit_code <= '0;
    end else if (w_xfer) begin
      r_exited <= w_exited_nxt;
      if (w_gnt == LAST_H)
        r_rr <= '0;
      else
        r_rr <= w_gnt + 1'b1;
      if (w_is_exit && w_code != '0 &&
          !r_failed) begin
        r_failed    <= 1'b1;
        r_fail_hart <= w_gnt;
        r_exit_code <= w_code;
      end
    end
  end

  // Console FIFO storage, pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_word[15:8];
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Saturating cycle counter, live only in RUN and DRAIN.
  always_ff @(posedge CLK) begin
    if (RST)
      r_cycles <= '0;
    else if ((r_state == S_RUN ||
              r_state == S_DRAIN) &&
             r_cycles != '1)
      r_cycles <= r_cycles + 1'b1;
  end

  assign con_valid = (r_cnt != '0);
  assign con_data  = con_valid ? r_mem[r_rp] : 8'h00;
  assign done      = (r_state == S_DONE);
  assign pass      = done && !r_failed;
  assign timeout   = (r_state == S_TIMEOUT);
  assign fail_hart = r_fail_hart;
  assign exit_code = r_exit_code;
  assign cycles    = r_cycles;

endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor: directed tables and sequences plus a
// randomized run against a queue-based reference model.
module tb_tohost_monitor;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        a_we;
  logic [31:0] a_th;
  logic        a_rdy;
  logic        a_cv;
  logic [7:0]  a_cd;
  logic        a_cr;
  logic        a_done;
  logic        a_pass;
  logic        a_to;
  logic [0:0]  a_fh;
  logic [30:0] a_ec;
  logic [31:0] a_cyc;

  logic [1:0]  b_we;
  logic [63:0] b_th;
  logic [1:0]  b_rdy;
  logic        b_cv;
  logic [7:0]  b_cd;
  logic        b_cr;
  logic        b_done;
  logic        b_pass;
  logic        b_to;
  logic [0:0]  b_fh;
  logic [30:0] b_ec;
  logic [31:0] b_cyc;

  tohost_monitor #(
    .NUM_HARTS(1), .XLEN(32), .CON_DEPTH(8),
    .TIMEOUT(50), .CYC_W(32)
  ) u_a (
    .CLK(CLK), .RST(RST),
    .tohost_we(a_we), .tohost(a_th),
    .tohost_ready(a_rdy),
    .con_valid(a_cv), .con_data(a_cd),
    .con_ready(a_cr),
    .done(a_done), .pass(a_pass),
    .timeout(a_to), .fail_hart(a_fh),
    .exit_code(a_ec), .cycles(a_cyc)
  );

  tohost_monitor #(
    .NUM_HARTS(2), .XLEN(32), .CON_DEPTH(8),
    .TIMEOUT(60), .CYC_W(32)
  ) u_b (
    .CLK(CLK), .RST(RST),
    .tohost_we(b_we), .tohost(b_th),
    .tohost_ready(b_rdy),
    .con_valid(b_cv), .con_data(b_cd),
    .con_ready(b_cr),
    .done(b_done), .pass(b_pass),
    .timeout(b_to), .fail_hart(b_fh),
    .exit_code(b_ec), .cycles(b_cyc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    a_we = 1'b0;
    b_we = 2'b00;
    a_cr = 1'b0;
    b_cr = 1'b0;
    a_th = '0;
    b_th = '0;
    step();
    RST = 1'b0;
  endtask

  // Reference model of hart set B (2 harts, depth 8, TO 60).
  int          m_st;
  bit [1:0]    m_ex;
  bit          m_f;
  int          m_fh;
  logic [30:0] m_ec;
  byte unsigned m_q[$];
  int          m_rr;
  int          m_cyc;

  task automatic m_reset();
    m_st  = 0;
    m_ex  = 2'b00;
    m_f   = 1'b0;
    m_fh  = 0;
    m_ec  = '0;
    m_q.delete();
    m_rr  = 0;
    m_cyc = 0;
  endtask

  task automatic rnd_cycle();
    int          g;
    int          h;
    int          kind;
    int          old_n;
    logic [31:0] v;
    logic [31:0] w;
    logic [1:0]  er;
    for (int k = 0; k < 2; k++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3, 4:
          v = ($urandom() & 32'hFFFF_FFFC) | 32'h2;
        5: v = $urandom() & 32'hFFFF_FFFC;
        6, 7: v = 32'h1;
        default:
          v = (32'($urandom_range(1, 999)) << 1) | 32'h1;
      endcase
      if (k == 0) b_th[31:0] = v;
      else        b_th[63:32] = v;
    end
    b_we = 2'($urandom());
    b_cr = ($urandom_range(0, 3) != 0);
    #1;
    g = -1;
    if (m_st == 0 && m_q.size() < 8)
      for (int k = 0; k < 2; k++) begin
        h = (m_rr + k) % 2;
        if (g < 0 && b_we[1'(h)] && !m_ex[1'(h)])
          g = h;
      end
    er = (g < 0) ? 2'b00 : 2'(1 << g);
    chk("rnd_ready", b_rdy, er);
    chk("rnd_cvalid", b_cv, m_q.size() != 0);
    if (m_q.size() != 0)
      chk("rnd_cdata", b_cd, m_q[0]);
    chk("rnd_done", b_done, m_st == 2);
    chk("rnd_pass", b_pass, m_st == 2 && !m_f);
    chk("rnd_timeout", b_to, m_st == 3);
    chk("rnd_cycles", b_cyc, m_cyc);
    if (m_f) begin
      chk("rnd_fhart", b_fh, m_fh);
      chk("rnd_ecode", b_ec, m_ec);
    end
    old_n = m_q.size();
    if (old_n != 0 && b_cr)
      void'(m_q.pop_front());
    if (g >= 0) begin
      w = (g == 0) ? b_th[31:0] : b_th[63:32];
      m_rr = (g + 1) % 2;
      if (w[0]) begin
        m_ex[1'(g)] = 1'b1;
        if (w[31:1] != 0 && !m_f) begin
          m_f  = 1'b1;
          m_fh = g;
          m_ec = w[31:1];
        end
      end else if (w[1]) begin
        m_q.push_back(w[15:8]);
      end
    end
    if (m_st < 2) begin
      if (m_cyc == 59)
        m_st = 3;
      else if (m_st == 0 && m_ex == 2'b11)
        m_st = 1;
      else if (m_st == 1 && old_n == 0)
        m_st = 2;
      m_cyc++;
    end
    step();
  endtask

  typedef struct {
    logic [1:0] we;
    logic       cr;
    logic [1:0] rdy;
    logic       cv;
    logic [7:0] cd;
  } vec_t;

  vec_t vt[6];
  int   acc;

  initial begin
    vt[0] = '{2'b11, 1'b1, 2'b01, 1'b0, 8'h00};
    vt[1] = '{2'b11, 1'b1, 2'b10, 1'b1, 8'h41};
    vt[2] = '{2'b11, 1'b1, 2'b01, 1'b1, 8'h42};
    vt[3] = '{2'b11, 1'b1, 2'b10, 1'b1, 8'h41};
    vt[4] = '{2'b00, 1'b1, 2'b00, 1'b1, 8'h42};
    vt[5] = '{2'b00, 1'b1, 2'b00, 1'b0, 8'h00};

    a_we = 1'b0; b_we = 2'b00;
    a_cr = 1'b0; b_cr = 1'b0;
    a_th = '0;   b_th = '0;
    @(negedge CLK);

    // Reset: requests held high must not be accepted.
    RST  = 1'b1;
    a_we = 1'b1; a_th = 32'h1;
    b_we = 2'b11; b_th = {32'h1, 32'h1};
    #1;
    chk("rst_a_ready", a_rdy, 1'b0);
    chk("rst_b_ready", b_rdy, 2'b00);
    step();
    do_reset();
    #1;
    chk("rst_b_cv", b_cv, 1'b0);
    chk("rst_b_done", b_done, 1'b0);
    chk("rst_b_pass", b_pass, 1'b0);
    chk("rst_b_to", b_to, 1'b0);
    chk("rst_b_cyc", b_cyc, 32'd0);
    chk("rst_b_fh", b_fh, 1'b0);
    chk("rst_b_ec", b_ec, 31'd0);
    chk("rst_a_cyc", a_cyc, 32'd0);

    // Single hart: exit 0 at cycle 5, DONE at cycle 7.
    do_reset();
    for (int i = 0; i < 5; i++) step();
    a_we = 1'b1; a_th = 32'h0000_0001;
    #1;
    chk("a_ready_c5", a_rdy, 1'b1);
    step();
    a_we = 1'b0;
    #1;
    chk("a_done_c6", a_done, 1'b0);
    step();
    #1;
    chk("a_done_c7", a_done, 1'b1);
    chk("a_pass_c7", a_pass, 1'b1);
    chk("a_ec_c7", a_ec, 31'd0);
    chk("a_cyc_c7", a_cyc, 32'd7);
    for (int i = 0; i < 3; i++) step();
    chk("a_cyc_frozen", a_cyc, 32'd7);

    // Single hart watchdog at 50 cycles.
    do_reset();
    for (int i = 0; i < 49; i++) step();
    #1;
    chk("a_cyc_49", a_cyc, 32'd49);
    chk("a_to_49", a_to, 1'b0);
    step();
    #1;
    chk("a_to_50", a_to, 1'b1);
    chk("a_cyc_50", a_cyc, 32'd50);
    chk("a_done_to", a_done, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("a_cyc_to_frozen", a_cyc, 32'd50);

    // First failure wins: hart1 code 3, then hart0 code 2.
    do_reset();
    b_we = 2'b10; b_th = {32'h7, 32'h0};
    #1;
    chk("ff_ready_h1", b_rdy, 2'b10);
    step();
    b_we = 2'b01; b_th = {32'h0, 32'h5};
    #1;
    chk("ff_ready_h0", b_rdy, 2'b01);
    step();
    b_we = 2'b00;
    #1;
    chk("ff_fhart", b_fh, 1'b1);
    chk("ff_ecode", b_ec, 31'd3);
    step();
    #1;
    chk("ff_done", b_done, 1'b1);
    chk("ff_pass", b_pass, 1'b0);
    chk("ff_fhart2", b_fh, 1'b1);
    chk("ff_ecode2", b_ec, 31'd3);

    // Alternating console grants, table-driven.
    do_reset();
    b_th = {32'h0000_4202, 32'h0000_4102};
    for (int i = 0; i < 6; i++) begin
      b_we = vt[i].we;
      b_cr = vt[i].cr;
      #1;
      chk($sformatf("alt_ready_%0d", i),
          b_rdy, vt[i].rdy);
      chk($sformatf("alt_cv_%0d", i),
          b_cv, vt[i].cv);
      if (vt[i].cv)
        chk($sformatf("alt_cd_%0d", i),
            b_cd, vt[i].cd);
      step();
    end

    // FIFO full blocks the ninth write until one pop.
    do_reset();
    acc = 0;
    b_cr = 1'b0;
    b_we = 2'b01;
    for (int i = 0; i < 8; i++) begin
      b_th = {32'h0, 16'h0, 8'(8'h30 + acc), 8'h02};
      #1;
      chk($sformatf("full_ready_%0d", i),
          b_rdy, 2'b01);
      acc++;
      step();
    end
    b_th = {32'h0, 16'h0, 8'(8'h30 + acc), 8'h02};
    #1;
    chk("full_blocked", b_rdy, 2'b00);
    chk("full_cv", b_cv, 1'b1);
    chk("full_head", b_cd, 8'h30);
    b_cr = 1'b1;
    step();
    b_cr = 1'b0;
    #1;
    chk("full_ninth_ready", b_rdy, 2'b01);
    chk("full_head2", b_cd, 8'h31);
    step();
    b_th = {32'h0, 32'h0000_3902};
    #1;
    chk("full_again", b_rdy, 2'b00);
    step();
    b_we = 2'b00;
    b_cr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("drain_cd_%0d", i),
          b_cd, 8'(8'h31 + i));
      step();
    end
    #1;
    chk("drain_empty", b_cv, 1'b0);

    // Reset mid-drain discards the FIFO.
    do_reset();
    b_cr = 1'b0;
    b_we = 2'b01;
    b_th = {32'h0, 32'h0000_7802};
    for (int i = 0; i < 3; i++) step();
    b_we = 2'b11;
    b_th = {32'h1, 32'h1};
    #1;
    chk("md_ready_h1", b_rdy, 2'b10);
    step();
    #1;
    chk("md_ready_h0", b_rdy, 2'b01);
    step();
    b_we = 2'b00;
    #1;
    chk("md_drain_done", b_done, 1'b0);
    chk("md_drain_cv", b_cv, 1'b1);
    RST = 1'b1;
    b_we = 2'b01;
    b_th = {32'h0, 32'h0000_7902};
    #1;
    chk("md_rst_ready", b_rdy, 2'b00);
    step();
    RST = 1'b0;
    #1;
    chk("md_cv", b_cv, 1'b0);
    chk("md_done", b_done, 1'b0);
    chk("md_pass", b_pass, 1'b0);
    chk("md_to", b_to, 1'b0);
    chk("md_cyc", b_cyc, 32'd0);
    chk("md_run_ready", b_rdy, 2'b01);
    step();
    b_we = 2'b00;
    #1;
    chk("md_new_char", b_cd, 8'h79);

    // Randomized segments against the model.
    for (int s = 0; s < 25; s++) begin
      do_reset();
      m_reset();
      for (int c = 0; c < 80; c++)
        rnd_cycle();
    end
    b_we = 2'b00;

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
